// File: rtl/regbank_readout.sv
// Serial readback engine: scans a DEPTH-word bank through a 1-cycle-latency
// read port and streams each word MSB-first over a valid/ready bit interface.
module regbank_readout #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_TOP   = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAP, SHIFT, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  // Outputs are loaded together with the state they belong to, so every
  // output is a flop and nothing combinational reaches them from so_ready.
  always_ff @(posedge CP) begin
    if (!CDN) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            addr    <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        REQ: begin
          state <= CAP;
          rd_en <= 1'b0;
        end
        CAP: begin
          state    <= SHIFT;
          shreg    <= rd_data;
          cnt      <= CNT_TOP;
          so       <= rd_data[WIDTH-1];
          so_valid <= 1'b1;
          so_last  <= 1'b0;
        end
        SHIFT: begin
          if (so_ready) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (cnt == '0) begin
              so       <= 1'b0;
              so_valid <= 1'b0;
              so_last  <= 1'b0;
              if (addr == LAST_ADDR) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state   <= REQ;
                addr    <= addr + AW'(1);
                rd_en   <= 1'b1;
                rd_addr <= addr + AW'(1);
              end
            end else begin
              cnt     <= cnt - CW'(1);
              so      <= shreg[WIDTH-2];
              so_last <= (cnt == CW'(1)) && (addr == LAST_ADDR);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          rd_en    <= 1'b0;
          so_valid <= 1'b0;
          so_last  <= 1'b0;
          so       <= 1'b0;
        end
      endcase
    end
  end
endmodule
